// File: rtl/requant_pipe_pkg.sv
// Shared types and clamp limits for the requantizer pipeline.
// Rounding-mode encoding, integer range constants and clamp-bound helpers.
package requant_pipe_pkg;

   typedef enum logic [1:0] {
      RND_HALF_UP   = 2'd0,
      RND_HALF_EVEN = 2'd1,
      RND_TRUNC     = 2'd2,
      RND_RSVD      = 2'd3
   } round_mode_e;

   localparam int INT8_MAX  = 127;
   localparam int INT8_MIN  = -128;
   localparam int INT16_MAX = 32767;
   localparam int INT16_MIN = -32768;

   function automatic int clamp_hi(input logic narrow);
      return narrow ? INT8_MAX : INT16_MAX;
   endfunction

   // ReLU replaces the lower bound, so a negative input clamps to zero.
   function automatic int clamp_lo(input logic narrow, input logic relu);
      if (relu)
         return 0;
      return narrow ? INT8_MIN : INT16_MIN;
   endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantizer: scale multiply (S1), round and shift (S2),
// clamp with saturation flag (S3). All stages advance together on en.
module requant_lane
   import requant_pipe_pkg::*;
#(
   parameter int ACC_W   = 32,
   parameter int SCALE_W = 8,
   parameter int SHIFT_W = 6,
   parameter int OUT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [ACC_W-1:0]   acc,
   input  logic [SCALE_W-1:0] scale,
   input  logic [SHIFT_W-1:0] shift,
   input  round_mode_e        s1_round,
   input  logic               s2_narrow,
   input  logic               s2_relu,
   output logic [OUT_W-1:0]   data,
   output logic               sat
);

   localparam int PW = ACC_W + SCALE_W + 1;
   localparam int IW = PW + 1;

   logic signed [PW-1:0]  prod_d;
   logic signed [PW-1:0]  prod_q;
   logic [SHIFT_W-1:0]    shift_q;
   logic signed [IW-1:0]  p_ext;
   logic signed [IW-1:0]  half;
   logic signed [IW-1:0]  term;
   logic signed [IW-1:0]  sum;
   logic signed [IW-1:0]  rnd_d;
   logic signed [IW-1:0]  rnd_q;
   logic signed [IW-1:0]  hi;
   logic signed [IW-1:0]  lo;
   logic                  lsb;
   logic [OUT_W-1:0]      data_d;
   logic                  sat_d;

   // Scale is unsigned; the zero pad keeps the multiply signed-correct.
   assign prod_d = $signed(acc) * $signed({1'b0, scale});

   always_comb begin
      p_ext = {prod_q[PW-1], prod_q};
      half  = '0;
      term  = '0;
      sum   = p_ext;
      lsb   = 1'b0;
      rnd_d = p_ext;
      if (shift_q == '0) begin
         rnd_d = p_ext;
      end else if (int'(shift_q) >= PW) begin
         // Any product is far below half of 2^shift here: rounding modes give 0,
         // floor gives the sign.
         rnd_d = (s1_round == RND_TRUNC && prod_q[PW-1]) ? '1 : '0;
      end else begin
         half = IW'(1) << (shift_q - 1'b1);
         lsb  = prod_q[shift_q];
         case (s1_round)
            RND_HALF_EVEN: term = half - IW'(1) + IW'(lsb);
            RND_TRUNC:     term = '0;
            default:       term = half;
         endcase
         sum   = p_ext + term;
         rnd_d = sum >>> shift_q;
      end
   end

   always_comb begin
      hi     = IW'(clamp_hi(s2_narrow));
      lo     = IW'(clamp_lo(s2_narrow, s2_relu));
      sat_d  = 1'b0;
      data_d = rnd_q[OUT_W-1:0];
      if (rnd_q > hi) begin
         sat_d  = 1'b1;
         data_d = hi[OUT_W-1:0];
      end else if (rnd_q < lo) begin
         sat_d  = 1'b1;
         data_d = lo[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q  <= '0;
         shift_q <= '0;
         rnd_q   <= '0;
         data    <= '0;
         sat     <= 1'b0;
      end else if (en) begin
         prod_q  <= prod_d;
         shift_q <= shift;
         rnd_q   <= rnd_d;
         data    <= data_d;
         sat     <= sat_d;
      end
   end

endmodule

// File: rtl/requant_pipe.sv
// Multi-lane 3-stage requantizer: per-lane scale/shift/round/clamp with a
// shared valid/ready pipeline, per-beat mode bits and a saturation counter.
module requant_pipe
   import requant_pipe_pkg::*;
#(
   parameter int LANES   = 16,
   parameter int ACC_W   = 32,
   parameter int SCALE_W = 8,
   parameter int SHIFT_W = 6,
   parameter int OUT_W   = 16,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*ACC_W-1:0]   in_acc,
   input  logic [LANES*SCALE_W-1:0] in_scale,
   input  logic [LANES*SHIFT_W-1:0] in_shift,
   input  logic [1:0]               in_round,
   input  logic                     in_narrow,
   input  logic                     in_relu,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*OUT_W-1:0]   out_data,
   output logic [LANES-1:0]         out_sat_mask,
   output logic [CNT_W-1:0]         sat_cnt,
   input  logic                     sat_clr
);

   localparam int PCW = $clog2(LANES + 1);

   logic          en;
   logic          v1;
   logic          v2;
   round_mode_e   r1_round;
   logic          r1_narrow;
   logic          r1_relu;
   logic          r2_narrow;
   logic          r2_relu;
   logic [PCW-1:0] sat_pop;
   logic [CNT_W:0] cnt_sum;

   // Handshake: a beat transfers on any edge where valid && ready. The whole
   // pipe moves as one unit, so the input is ready exactly when the output
   // slot is empty or being drained; a stalled output holds every stage.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         r1_round  <= RND_HALF_UP;
         r1_narrow <= 1'b0;
         r1_relu   <= 1'b0;
         r2_narrow <= 1'b0;
         r2_relu   <= 1'b0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         r1_round  <= round_mode_e'(in_round);
         r1_narrow <= in_narrow;
         r1_relu   <= in_relu;
         r2_narrow <= r1_narrow;
         r2_relu   <= r1_relu;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      requant_lane #(
         .ACC_W   (ACC_W),
         .SCALE_W (SCALE_W),
         .SHIFT_W (SHIFT_W),
         .OUT_W   (OUT_W)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .acc       (in_acc[g*ACC_W +: ACC_W]),
         .scale     (in_scale[g*SCALE_W +: SCALE_W]),
         .shift     (in_shift[g*SHIFT_W +: SHIFT_W]),
         .s1_round  (r1_round),
         .s2_narrow (r2_narrow),
         .s2_relu   (r2_relu),
         .data      (out_data[g*OUT_W +: OUT_W]),
         .sat       (out_sat_mask[g])
      );
   end

   always_comb begin
      sat_pop = '0;
      for (int i = 0; i < LANES; i++)
         sat_pop = sat_pop + PCW'(out_sat_mask[i]);
   end

   assign cnt_sum = {1'b0, sat_cnt} + (CNT_W+1)'(sat_pop);

   // Clear wins over a same-cycle delivery; the count sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= '0;
      end else if (sat_clr) begin
         sat_cnt <= '0;
      end else if (out_valid && out_ready) begin
         sat_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_requant_pipe.sv
// Self-checking bench for requant_pipe: arithmetic reference model, expected
// queue scoreboard, directed corner cases and randomized traffic.
module tb_requant_pipe;

   localparam int LANES   = 16;
   localparam int ACC_W   = 32;
   localparam int SCALE_W = 8;
   localparam int SHIFT_W = 6;
   localparam int OUT_W   = 16;
   localparam int CNT_W   = 16;
   localparam int W       = LANES*OUT_W + LANES;
   localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

   logic                     clk;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*ACC_W-1:0]   in_acc;
   logic [LANES*SCALE_W-1:0] in_scale;
   logic [LANES*SHIFT_W-1:0] in_shift;
   logic [1:0]               in_round;
   logic                     in_narrow;
   logic                     in_relu;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*OUT_W-1:0]   out_data;
   logic [LANES-1:0]         out_sat_mask;
   logic [CNT_W-1:0]         sat_cnt;
   logic                     sat_clr;

   requant_pipe #(
      .LANES(LANES), .ACC_W(ACC_W), .SCALE_W(SCALE_W),
      .SHIFT_W(SHIFT_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_acc(in_acc), .in_scale(in_scale), .in_shift(in_shift),
      .in_round(in_round), .in_narrow(in_narrow), .in_relu(in_relu),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat_mask(out_sat_mask), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ACC_W-1:0]   b_acc   [LANES];
   logic [SCALE_W-1:0] b_scale [LANES];
   logic [SHIFT_W-1:0] b_shift [LANES];

   logic [W-1:0] exp_q[$];
   longint cnt_m = 0;
   bit     rand_ready = 0;
   bit     rand_clr = 0;

   int  cyc_n = 0;
   bit  lat_arm = 0;
   int  first_acc = -1;
   int  first_out = -1;
   int  last_out = -1;
   int  n_out = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint model_lane(input longint acc, input longint scale, input int sh,
                                         input int rnd, input bit nar, input bit rl,
                                         output bit sat);
      longint p, q, rem, half, r, hi, lo;
      p = acc * scale;
      if (sh == 0) begin
         r = p;
      end else if (sh >= 48) begin
         r = (rnd == 2 && p < 0) ? -1 : 0;
      end else begin
         q    = p >>> sh;
         rem  = p - q * (longint'(1) << sh);
         half = longint'(1) << (sh - 1);
         if (rnd == 2)
            r = q;
         else if (rnd == 1)
            r = (rem > half || (rem == half && (q % 2) != 0)) ? q + 1 : q;
         else
            r = (rem >= half) ? q + 1 : q;
      end
      hi  = nar ? 127 : 32767;
      lo  = rl ? 0 : (nar ? -128 : -32768);
      sat = (r > hi) || (r < lo);
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

   function automatic logic [W-1:0] model_beat();
      logic [LANES*OUT_W-1:0] d;
      logic [LANES-1:0]       m;
      logic signed [ACC_W-1:0] a;
      longint r;
      bit s;
      d = '0;
      m = '0;
      for (int i = 0; i < LANES; i++) begin
         a = in_acc[i*ACC_W +: ACC_W];
         r = model_lane(longint'(a), longint'(in_scale[i*SCALE_W +: SCALE_W]),
                        int'(in_shift[i*SHIFT_W +: SHIFT_W]), int'(in_round),
                        in_narrow, in_relu, s);
         d[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
         m[i] = s;
      end
      return {m, d};
   endfunction

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      logic [W-1:0] front;
      longint inc;
      cyc_n++;
      inc = 0;
      if (rst) begin
         exp_q.delete();
         cnt_m = 0;
      end else begin
         check("sat_cnt", longint'(sat_cnt), cnt_m);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               front = exp_q[0];
               n_checks++;
               if ({out_sat_mask, out_data} !== front) begin
                  n_fail++;
                  $display("FAIL beat: got mask=%h data=%h, expected mask=%h data=%h",
                           out_sat_mask, out_data, front[W-1 -: LANES], front[LANES*OUT_W-1:0]);
               end
               if (out_ready) begin
                  inc = longint'($countones(front[W-1 -: LANES]));
                  void'(exp_q.pop_front());
               end
            end
         end
         if (sat_clr)
            cnt_m = 0;
         else if (cnt_m + inc > CNT_MAX)
            cnt_m = CNT_MAX;
         else
            cnt_m = cnt_m + inc;
         if (in_valid && in_ready)
            exp_q.push_back(model_beat());
         if (lat_arm) begin
            if (in_valid && in_ready && first_acc < 0) first_acc = cyc_n;
            if (out_valid && out_ready) begin
               if (first_out < 0) first_out = cyc_n;
               last_out = cyc_n;
               n_out++;
            end
         end
      end
   end

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic set_all(input longint acc, input int sc, input int sh);
      for (int i = 0; i < LANES; i++) begin
         b_acc[i]   = ACC_W'(acc);
         b_scale[i] = SCALE_W'(sc);
         b_shift[i] = SHIFT_W'(sh);
      end
   endtask

   task automatic set_sat4();
      set_all(5, 1, 0);
      for (int i = 0; i < 4; i++) b_acc[i] = ACC_W'(100000);
   endtask

   task automatic send_beat(input logic [1:0] rnd, input logic nar, input logic rl);
      bit ok;
      int t;
      for (int i = 0; i < LANES; i++) begin
         in_acc[i*ACC_W +: ACC_W]       = b_acc[i];
         in_scale[i*SCALE_W +: SCALE_W] = b_scale[i];
         in_shift[i*SHIFT_W +: SHIFT_W] = b_shift[i];
      end
      in_round  = rnd;
      in_narrow = nar;
      in_relu   = rl;
      in_valid  = 1'b1;
      ok = 0;
      t  = 0;
      while (!ok && t < 200) begin
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
         if (rand_clr)   sat_clr   = ($urandom_range(0, 31) == 0);
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!ok) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic send_random_beat();
      int v;
      for (int i = 0; i < LANES; i++) begin
         v = int'($urandom_range(0, 8000)) - 4000;
         b_acc[i]   = ($urandom_range(0, 1) == 1) ? ACC_W'($urandom) : ACC_W'(v);
         b_scale[i] = SCALE_W'($urandom_range(0, 255));
         b_shift[i] = ($urandom_range(0, 3) == 0) ? SHIFT_W'($urandom_range(0, 63))
                                                  : SHIFT_W'($urandom_range(0, 16));
      end
      send_beat(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int t;
      rand_ready = 0;
      out_ready  = 1'b1;
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 60) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain_empty", longint'(exp_q.size()), 0);
   endtask

   task automatic expect_lane0(input string name, input longint exp_d, input bit exp_s);
      int t;
      logic signed [OUT_W-1:0] d;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) begin
         check({name, "_timeout"}, 0, 1);
      end else begin
         d = out_data[OUT_W-1:0];
         check(name, longint'(d), exp_d);
         check({name, "_sat"}, longint'(out_sat_mask[0]), longint'(exp_s));
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit s;
      int t;
      rst = 1'b1;
      in_valid = 1'b0;
      in_acc = '0;
      in_scale = '0;
      in_shift = '0;
      in_round = 2'd0;
      in_narrow = 1'b0;
      in_relu = 1'b0;
      out_ready = 1'b0;
      sat_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_data_zero", longint'(out_data == '0), 1);
      check("rst_mask", longint'(out_sat_mask), 0);
      check("rst_sat_cnt", longint'(sat_cnt), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Model pins against hand-derived numbers.
      check("pin_1000_hu", model_lane(1000, 3, 5, 0, 0, 0, s), 94);
      check("pin_1000_he", model_lane(1000, 3, 5, 1, 0, 0, s), 94);
      check("pin_1000_tr", model_lane(1000, 3, 5, 2, 0, 0, s), 93);
      check("pin_16_hu", model_lane(16, 1, 5, 0, 0, 0, s), 1);
      check("pin_16_he", model_lane(16, 1, 5, 1, 0, 0, s), 0);
      check("pin_48_he", model_lane(48, 1, 5, 1, 0, 0, s), 2);
      check("pin_48_tr", model_lane(48, 1, 5, 2, 0, 0, s), 1);
      check("pin_m48_hu", model_lane(-48, 1, 5, 0, 0, 0, s), -1);
      check("pin_m48_he", model_lane(-48, 1, 5, 1, 0, 0, s), -2);
      check("pin_m200_nar", model_lane(-200, 1, 0, 0, 1, 0, s), -128);
      check("pin_m200_nar_sat", longint'(s), 1);

      // Directed rounding and clamp beats through the DUT.
      out_ready = 1'b1;
      set_all(1000, 3, 5);  send_beat(2'd0, 1'b0, 1'b0); expect_lane0("dut_1000_hu", 94, 0);
      set_all(1000, 3, 5);  send_beat(2'd2, 1'b0, 1'b0); expect_lane0("dut_1000_tr", 93, 0);
      set_all(16, 1, 5);    send_beat(2'd0, 1'b0, 1'b0); expect_lane0("dut_16_hu", 1, 0);
      set_all(16, 1, 5);    send_beat(2'd1, 1'b0, 1'b0); expect_lane0("dut_16_he", 0, 0);
      set_all(48, 1, 5);    send_beat(2'd1, 1'b0, 1'b0); expect_lane0("dut_48_he", 2, 0);
      set_all(-48, 1, 5);   send_beat(2'd0, 1'b0, 1'b0); expect_lane0("dut_m48_hu", -1, 0);
      set_all(-48, 1, 5);   send_beat(2'd1, 1'b0, 1'b0); expect_lane0("dut_m48_he", -2, 0);
      set_all(-48, 1, 5);   send_beat(2'd3, 1'b0, 1'b0); expect_lane0("dut_m48_rsvd", -1, 0);
      set_all(100000, 1, 0); send_beat(2'd0, 1'b1, 1'b0); expect_lane0("dut_sat_nar", 127, 1);
      set_all(100000, 1, 0); send_beat(2'd0, 1'b0, 1'b0); expect_lane0("dut_sat_wide", 32767, 1);
      set_all(-200, 1, 0);  send_beat(2'd0, 1'b1, 1'b0); expect_lane0("dut_m200_nar", -128, 1);
      set_all(-200, 1, 0);  send_beat(2'd0, 1'b1, 1'b1); expect_lane0("dut_m200_relu", 0, 1);
      set_all(5, 1, 0);     send_beat(2'd0, 1'b1, 1'b1); expect_lane0("dut_5_relu", 5, 0);
      drain();

      // Latency and throughput with a free-running sink.
      first_acc = -1; first_out = -1; last_out = -1; n_out = 0;
      lat_arm = 1;
      repeat (8) send_random_beat();
      drain();
      lat_arm = 0;
      check("latency", longint'(first_out - first_acc), 3);
      check("throughput_span", longint'(last_out - first_out), 7);
      check("beats_out", longint'(n_out), 8);

      // Mid-stream stall of five cycles.
      out_ready = 1'b1;
      repeat (4) send_random_beat();
      out_ready = 1'b0;
      fork
         begin
            repeat (4) send_random_beat();
         end
         begin
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", longint'(in_ready), 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Per-lane independence: lane i sees 2^i >> i with half-up.
      for (int i = 0; i < LANES; i++) begin
         b_acc[i]   = ACC_W'(1 << i);
         b_scale[i] = SCALE_W'(1);
         b_shift[i] = SHIFT_W'(i);
      end
      send_beat(2'd0, 1'b0, 1'b0);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin @(negedge clk); t++; end
      for (int i = 0; i < LANES; i++)
         check($sformatf("lane_%0d", i), longint'(out_data[i*OUT_W +: OUT_W]), 1);
      @(posedge clk);
      #1;
      drain();

      // Counter: three beats of four saturated lanes.
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      set_sat4();
      repeat (3) send_beat(2'd0, 1'b1, 1'b0);
      drain();
      @(negedge clk);
      check("sat_cnt_12", longint'(sat_cnt), 12);
      @(posedge clk);
      #1;

      // Clear coinciding with a saturating delivery.
      out_ready = 1'b0;
      set_sat4();
      send_beat(2'd0, 1'b1, 1'b0);
      idle(3);
      check("clr_beat_waiting", longint'(out_valid), 1);
      out_ready = 1'b1;
      sat_clr   = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      @(negedge clk);
      check("sat_cnt_clr_wins", longint'(sat_cnt), 0);
      @(posedge clk);
      #1;
      drain();

      // Randomized traffic with random backpressure and clears.
      rand_ready = 1;
      rand_clr   = 1;
      for (int n = 0; n < 400; n++) begin
         send_random_beat();
         if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
      end
      rand_clr = 0;
      sat_clr  = 1'b0;
      drain();

      // Sticky counter: every lane saturates on every beat.
      out_ready = 1'b1;
      set_all(100000, 1, 0);
      repeat (4100) send_beat(2'd0, 1'b1, 1'b0);
      drain();
      @(negedge clk);
      check("sat_cnt_sticky", longint'(sat_cnt), CNT_MAX);
      @(posedge clk);
      #1;

      // Reset with two beats in flight.
      out_ready = 1'b1;
      repeat (2) send_random_beat();
      rst = 1'b1;
      #1;
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_sat_cnt", longint'(sat_cnt), 0);
      check("midrst_data_zero", longint'(out_data == '0), 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(8);
      check("post_rst_no_beat", longint'(out_valid), 0);
      check("post_rst_queue", longint'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/requant_pipe.md
Name: requant_pipe

Overview:
- Multi-lane, 3-stage pipelined requantizer that sits between the GEMM accumulator drain and activation SRAM write-back.
- It is the sequential, parametrised successor of the package-level requantize/saturate functions:
  - per-lane scale/shift
  - three rounding modes
  - INT8 or INT16 output clamp
  - optional ReLU
  - valid/ready backpressure
  - saturation statistics
- Each beat carries LANES INT32 accumulators and produces LANES clamped results.

Parameters:
- LANES, 16, lanes per beat (matches ARRAY_N)
- ACC_W, 32, signed accumulator width per lane
- SCALE_W, 8, unsigned per-lane scale width
- SHIFT_W, 6, per-lane right-shift width (0..63)
- OUT_W, 16, output lane width; narrow results are sign-extended into it
- CNT_W, 16, saturation counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_acc  in  LANES*ACC_W  signed accumulators, lane i at [i*ACC_W +: ACC_W]
- in_scale  in  LANES*SCALE_W  per-lane unsigned scale
- in_shift  in  LANES*SHIFT_W  per-lane shift
- in_round  in  2  0=half-up, 1=half-even, 2=truncate(floor), 3=reserved (treated as half-up)
- in_narrow  in  1  1=clamp to INT8 range, 0=clamp to INT16 range
- in_relu  in  1  1=lower clamp bound is 0
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*OUT_W  signed results
- out_sat_mask  out  LANES  per-lane "result was clamped" flags for this beat
- sat_cnt  out  CNT_W  saturating count of clamped lanes in delivered beats
- sat_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset: all stage valids, out_valid, out_data, out_sat_mask and sat_cnt are 0. Reset mid-stream discards all in-flight beats.
- Pipeline:
  - S1 registers product = acc * {0,scale}, signed, ACC_W+SCALE_W+1 bits.
  - S2 registers the rounded, arithmetically shifted value.
  - S3 registers the clamped output and the mask.
- Mode bits (in_round, in_narrow, in_relu) are sampled per beat and travel with the data. Mixed modes on back-to-back beats are legal.
- Latency: 3 cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle.
- Stall: en = !out_valid || out_ready. All stages advance only when en is high; in_ready = en. No beat is dropped or duplicated. out_data and out_sat_mask stay stable while out_valid && !out_ready.
- Rounding, with h = 1<<(shift-1):
  - half-up: p + h
  - half-even: p + h - 1 + p[shift]
  - truncate: p
  - Then apply >>> shift.
  - shift==0: no rounding term in any mode.
  - The intermediate is one bit wider than the product so the add cannot overflow. A shift exceeding the product width yields 0 or -1 exactly.
- Clamp:
  - hi = 127 if narrow, else 32767.
  - lo = 0 if relu; else -128 if narrow, else -32768.
  - The mask bit is set if the value is above hi or below lo. A ReLU clamp of a negative value counts as saturation.
- sat_cnt:
  - On out_valid&&out_ready, add popcount(out_sat_mask).
  - Sticks at all-ones; no wrap.
  - sat_clr has priority: the counter goes to 0 and that cycle's increment is dropped.

Decomposition:
- npu_pkg additions:
  - round-mode enum: RND_HALF_UP=0, RND_HALF_EVEN=1, RND_TRUNC=2
  - constants INT8_MAX/MIN, INT16_MAX/MIN
  - the existing saturate helpers are reused for reference modelling
- Sub-module requant_lane: one lane's arithmetic across S1-S3, enable-driven.
- The top level instantiates LANES copies and owns valids, handshake, mode pipeline and sat_cnt.

Test Plan:
- Rounding: acc=1000, scale=3, shift=5 -> half-up 94, half-even 94, trunc 93. acc=16, scale=1, shift=5 -> 1/0/0. acc=48 -> 2/2/1. acc=-48 -> -1/-2/-2.
- Saturation: acc=100000, scale=1, shift=0 -> narrow 127, wide 32767, mask=1. acc=-200 -> narrow -128. With relu -> 0, mask=1. acc=5 with relu -> 5, mask=0.
- Latency and stall:
  - 8 beats streamed with out_ready=1 -> first out_valid 3 cycles after first accept, then 1 beat/cycle.
  - Hold out_ready=0 for 5 cycles mid-stream -> in_ready low, outputs stable, all 8 beats delivered in order.
- Per-lane independence: lane i uses shift=i, acc=1<<i, scale=1 -> every lane outputs 1 with half-up.
- Counter:
  - 3 beats with 4 saturated lanes each -> sat_cnt=12.
  - sat_clr on the same cycle as a delivery of a 4-saturating beat -> sat_cnt=0.
  - Preload to near max via many beats -> sticks at 2^CNT_W-1.
- Reset: assert rst with 2 beats in flight -> out_valid=0 immediately, sat_cnt=0, no stale beat emerges after release.
